// File: rtl/int_mac_pipe_if.sv
// Beat/result handshake bundle for int_mac_pipe.
// The upstream and downstream side (master) drives the operands and out_ready; the MAC (slave) drives the rest.
interface int_mac_pipe_if #(
    parameter int LANES     = 64,
    parameter int HDR_LANES = 2,
    parameter int ACC_W     = 24
);
    localparam int VW = (LANES + HDR_LANES) * 4;

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_first;
    logic                    in_last;
    logic                    mode;
    logic [VW-1:0]           a_vec;
    logic [VW-1:0]           b_vec;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] acc_out;
    logic                    ovf;

    modport master (
        output in_valid, in_first, in_last, mode, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, acc_out, ovf
    );

    modport slave (
        input  in_valid, in_first, in_last, mode, a_vec, b_vec, out_ready,
        output in_ready, out_valid, acc_out, ovf
    );
endinterface

// File: rtl/int_mac_pipe.sv
// Pipelined INT4/INT8 dot-product accumulator: products -> adder tree -> accumulate -> result register.
// One 8-bit lane pair per sub-module; a pair yields two INT4 products or one INT8 product.
module int_mac_pair (
    input  logic        i_mode,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [16:0] o_p
);
    logic signed [16:0] w_alo, w_ahi, w_blo, w_bhi, w_a8, w_b8;

    assign w_alo = 17'($signed(i_a[3:0]));
    assign w_ahi = 17'($signed(i_a[7:4]));
    assign w_blo = 17'($signed(i_b[3:0]));
    assign w_bhi = 17'($signed(i_b[7:4]));
    assign w_a8  = 17'($signed(i_a));
    assign w_b8  = 17'($signed(i_b));
    assign o_p   = i_mode ? w_a8 * w_b8 : w_alo * w_blo + w_ahi * w_bhi;
endmodule

module int_mac_pipe #(
    parameter int LANES     = 64,
    parameter int HDR_LANES = 2,
    parameter int ACC_W     = 24,
    parameter int SAT       = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    int_mac_pipe_if.slave  bus
);
    localparam int PAIRS = LANES / 2;
    localparam int PW    = 17;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic                         w_en, w_accept, w_mode;
    logic [LANES*4-1:0]           w_a_act, w_b_act;
    logic [PAIRS-1:0][PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_sum, w_base, w_acc_nxt;
    logic signed [ACC_W:0]        w_tot;
    logic                         w_start, w_of, w_ovf_nxt;
    logic                         w_unused_hdr;

    logic [3:1]                   r_vld_pipe;
    logic [2:1]                   r_first;
    logic [3:1]                   r_last;
    logic [PAIRS-1:0][PW-1:0]     r_prod;
    logic signed [ACC_W-1:0]      r_sum, r_acc, r_out;
    logic                         r_grp_ovf, r_open, r_out_vld, r_out_ovf;

    // A held result blocks the whole pipe so nothing behind it can be overwritten.
    assign w_en          = !(r_out_vld && !bus.out_ready);
    assign w_accept      = bus.in_valid && w_en;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_vld;
    assign bus.acc_out   = r_out;
    assign bus.ovf       = r_out_ovf;

    assign w_mode        = bus.mode;
    assign w_a_act       = bus.a_vec[4*HDR_LANES +: 4*LANES];
    assign w_b_act       = bus.b_vec[4*HDR_LANES +: 4*LANES];
    assign w_unused_hdr  = ^{bus.a_vec[4*HDR_LANES-1:0], bus.b_vec[4*HDR_LANES-1:0]};

    int_mac_pair u_pair [PAIRS-1:0] (
        .i_mode (w_mode),
        .i_a    (w_a_act),
        .i_b    (w_b_act),
        .o_p    (w_prod)
    );

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < PAIRS; k++)
            w_sum = w_sum + ACC_W'($signed(r_prod[k]));
    end

    // A group restarts on an explicit first beat or on any beat following a completed group.
    always_comb begin
        w_start   = r_first[2] || !r_open;
        w_base    = w_start ? '0 : r_acc;
        w_tot     = {w_base[ACC_W-1], w_base} + {r_sum[ACC_W-1], r_sum};
        w_of      = w_tot[ACC_W] != w_tot[ACC_W-1];
        w_acc_nxt = w_tot[ACC_W-1:0];
        if (SAT != 0 && w_of)
            w_acc_nxt = w_tot[ACC_W] ? ACC_MIN : ACC_MAX;
        w_ovf_nxt = w_of || (!w_start && r_grp_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_first    <= '0;
            r_last     <= '0;
            r_prod     <= '0;
            r_sum      <= '0;
            r_acc      <= '0;
            r_grp_ovf  <= 1'b0;
            r_open     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out      <= '0;
            r_out_ovf  <= 1'b0;
        end else if (clr) begin
            r_vld_pipe <= '0;
            r_first    <= '0;
            r_last     <= '0;
            r_prod     <= '0;
            r_sum      <= '0;
            r_acc      <= '0;
            r_grp_ovf  <= 1'b0;
            r_open     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out      <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[2:1], w_accept};
            r_first    <= {r_first[1], bus.in_first};
            r_last     <= {r_last[2:1], bus.in_last};
            r_prod     <= w_prod;
            r_sum      <= w_sum;
            if (r_vld_pipe[2]) begin
                r_acc     <= w_acc_nxt;
                r_grp_ovf <= w_ovf_nxt;
                r_open    <= !r_last[2];
            end
            if (r_vld_pipe[3] && r_last[3]) begin
                r_out_vld <= 1'b1;
                r_out     <= r_acc;
                r_out_ovf <= r_grp_ovf;
            end else if (bus.out_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_int_mac_pipe.sv
// Randomised and directed bench for int_mac_pipe with a queue scoreboard and a lane-level reference model.
module tb_int_mac_pipe;
    localparam int LANES = 64;
    localparam int HDR   = 2;
    localparam int ACC_W = 24;
    localparam int SAT   = 1;
    localparam int VW    = (LANES + HDR) * 4;
    localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));
    localparam longint SPAN = 64'sd1 <<< ACC_W;

    typedef struct {
        longint acc;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    int_mac_pipe_if #(.LANES(LANES), .HDR_LANES(HDR), .ACC_W(ACC_W)) bus();

    int_mac_pipe #(.LANES(LANES), .HDR_LANES(HDR), .ACC_W(ACC_W), .SAT(SAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t   q[$];
    longint out_log[$];
    int     checks = 0;
    int     failures = 0;
    int     n_out = 0;
    longint last_acc = 0;
    longint last_ovf = 0;
    longint m_acc = 0;
    bit     m_open = 1'b0;
    bit     m_ovf = 1'b0;
    bit     rnd_bp = 1'b0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int nib(logic [VW-1:0] v, int j);
        return int'(v[4*j +: 4]);
    endfunction

    function automatic longint beat_sum(bit mode, logic [VW-1:0] a, logic [VW-1:0] b);
        longint s = 0;
        int xa, xb;
        if (!mode) begin
            for (int j = 0; j < LANES; j++) begin
                xa = nib(a, HDR + j);
                xb = nib(b, HDR + j);
                if (xa >= 8) xa -= 16;
                if (xb >= 8) xb -= 16;
                s += longint'(xa * xb);
            end
        end else begin
            for (int k = 0; k < LANES / 2; k++) begin
                xa = nib(a, HDR + 2*k) + 16 * nib(a, HDR + 2*k + 1);
                xb = nib(b, HDR + 2*k) + 16 * nib(b, HDR + 2*k + 1);
                if (xa >= 128) xa -= 256;
                if (xb >= 128) xb -= 256;
                s += longint'(xa * xb);
            end
        end
        return s;
    endfunction

    task automatic model_beat(bit mode, bit first, bit last, logic [VW-1:0] a, logic [VW-1:0] b);
        bit     start = first || !m_open;
        bit     of;
        longint t = (start ? 64'sd0 : m_acc) + beat_sum(mode, a, b);
        of = (t > AMAX) || (t < AMIN);
        if (of) begin
            if (SAT != 0) t = (t > AMAX) ? AMAX : AMIN;
            else begin
                t = (t - AMIN) % SPAN;
                if (t < 0) t += SPAN;
                t += AMIN;
            end
        end
        m_acc = t;
        m_ovf = start ? of : (m_ovf | of);
        if (last) begin
            q.push_back('{t, m_ovf});
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    task automatic model_flush();
        q.delete();
        m_acc  = 0;
        m_open = 1'b0;
        m_ovf  = 1'b0;
    endtask

    function automatic logic [VW-1:0] fill4(int av, int hv);
        logic [VW-1:0] v = '0;
        logic [3:0] an = av[3:0];
        logic [3:0] hn = hv[3:0];
        for (int j = 0; j < LANES + HDR; j++) v[4*j +: 4] = (j < HDR) ? hn : an;
        return v;
    endfunction

    function automatic logic [VW-1:0] fill8(int bv, int hv);
        logic [VW-1:0] v = '0;
        logic [7:0] bb = bv[7:0];
        logic [3:0] hn = hv[3:0];
        for (int j = 0; j < HDR; j++) v[4*j +: 4] = hn;
        for (int k = 0; k < LANES / 2; k++) v[4*(HDR + 2*k) +: 8] = bb;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v = '0;
        for (int j = 0; j < LANES + HDR; j++) v[4*j +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic send(bit mode, bit first, bit last, logic [VW-1:0] a, logic [VW-1:0] b);
        int n = 0;
        @(negedge clk);
        bus.mode = mode;
        bus.in_first = first;
        bus.in_last = last;
        bus.a_vec = a;
        bus.b_vec = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low expected=accept");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_beat(mode, first, last, a, b);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending expected=0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                n_out++;
                last_acc = longint'($signed(bus.acc_out));
                last_ovf = longint'(bus.ovf);
                out_log.push_back(last_acc);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0d expected=none", last_acc);
                end else begin
                    e = q.pop_front();
                    check("sb_acc", last_acc, e.acc);
                    check("sb_ovf", last_ovf, longint'(e.ovf));
                end
            end
        end
    end

    initial begin : backpressure
        forever begin
            @(posedge clk);
            #2;
            if (rnd_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : stim
        int n0, nw;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last = 1'b0;
        bus.mode = 1'b0;
        bus.a_vec = '0;
        bus.b_vec = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_acc_out", longint'($signed(bus.acc_out)), 0);
        check("rst_ovf", longint'(bus.ovf), 0);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single beat latency and header isolation
        send(1'b0, 1'b1, 1'b1, fill4(1, 15), fill4(1, 15));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("lat_early_valid", longint'(bus.out_valid), 0);
        @(negedge clk);
        check("lat_t3_valid", longint'(bus.out_valid), 1);
        check("lat_t3_acc", longint'($signed(bus.acc_out)), 64);
        drain();

        // three back-to-back INT4 beats of -8*-8
        n0 = n_out;
        send(1'b0, 1'b1, 1'b0, fill4(8, 3), fill4(8, 5));
        send(1'b0, 1'b0, 1'b0, fill4(8, 3), fill4(8, 5));
        send(1'b0, 1'b0, 1'b1, fill4(8, 3), fill4(8, 5));
        drain();
        check("int4_group_acc", last_acc, 12288);
        check("int4_group_pulses", longint'(n_out - n0), 1);

        // INT8 saturation then a fresh group
        for (int i = 0; i < 16; i++)
            send(1'b1, i == 0, i == 15, fill8(8'h80, 9), fill8(8'h80, 6));
        drain();
        check("int8_sat_acc", last_acc, 8388607);
        check("int8_sat_ovf", last_ovf, 1);
        send(1'b1, 1'b1, 1'b1, fill8(1, 15), fill8(1, 15));
        drain();
        check("int8_next_acc", last_acc, 32);
        check("int8_next_ovf", last_ovf, 0);

        // output stall holds the result and blocks input
        out_log.delete();
        bus.out_ready = 1'b0;
        send(1'b0, 1'b1, 1'b1, fill4(1, 7), fill4(1, 2));
        send(1'b0, 1'b1, 1'b1, fill4(2, 7), fill4(1, 2));
        nw = 0;
        while (!bus.out_valid && nw < 50) begin
            @(negedge clk);
            nw++;
        end
        check("stall_valid_seen", longint'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_acc_hold", longint'($signed(bus.acc_out)), 64);
            check("stall_in_ready", longint'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();
        check("stall_count", longint'(out_log.size()), 2);
        if (out_log.size() == 2) begin
            check("stall_order0", out_log[0], 64);
            check("stall_order1", out_log[1], 128);
        end

        // clr one cycle after a last beat kills it
        n0 = n_out;
        send(1'b0, 1'b1, 1'b1, fill4(1, 0), fill4(1, 0));
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_flush();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("clr_no_valid", longint'(bus.out_valid), 0);
        end
        check("clr_no_pulse", longint'(n_out - n0), 0);
        send(1'b0, 1'b1, 1'b1, fill4(2, 0), fill4(1, 0));
        drain();
        check("clr_next_acc", last_acc, 128);

        // asynchronous reset mid-group
        send(1'b0, 1'b1, 1'b0, fill4(3, 1), fill4(3, 1));
        send(1'b0, 1'b0, 1'b0, fill4(3, 1), fill4(3, 1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", longint'(bus.out_valid), 0);
        check("arst_acc_out", longint'($signed(bus.acc_out)), 0);
        check("arst_ovf", longint'(bus.ovf), 0);
        check("arst_in_ready", longint'(bus.in_ready), 1);
        model_flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 1'b0, 1'b1, fill4(1, 4), fill4(1, 4));
        drain();
        check("arst_next_acc", last_acc, 64);

        // randomised beats, mixed modes, random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 80; i++) begin
            bit f = (i == 0) || ($urandom_range(0, 3) == 0);
            bit l = (i == 79) || ($urandom_range(0, 2) == 0);
            send(1'($urandom_range(0, 1)), f, l, rand_vec(), rand_vec());
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #3 bus.out_ready = 1'b1;
        drain();
        check("final_queue_empty", longint'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/int_mac_pipe.md
INT_MAC_PIPE -- requirements
Module: int_mac_pipe

Interface
REQ-001 Parameter LANES, default 64, meaning: active 4-bit lanes per operand vector; even power of two.
REQ-002 Parameter HDR_LANES, default 2, meaning: low-order 4-bit header lanes carried in each vector and excluded from arithmetic.
REQ-003 Parameter ACC_W, default 24, meaning: signed accumulator and result width.
REQ-004 Parameter SAT, default 1, meaning: 1 = saturating accumulate; 0 = two's-complement wrap.
REQ-005 clk  input  1  rising-edge clock; the only clock.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous flush of the pipeline and accumulator.
REQ-008 mode  input  1  0 = INT4, 1 = INT8; sampled per accepted beat.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  block can accept a beat.
REQ-011 in_first  input  1  beat starts a new accumulation group.
REQ-012 in_last  input  1  beat ends the group; its result is emitted.
REQ-013 a_vec, b_vec  input  (LANES+HDR_LANES)*4 each  packed operands; lane j = bits [4j+3:4j].
REQ-014 out_valid  output  1  acc_out/ovf valid.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 acc_out  output  ACC_W  signed group result.
REQ-017 ovf  output  1  group overflowed at some accumulate step; valid with out_valid.

Function
REQ-018 Lanes 0..HDR_LANES-1 shall never affect any output.
REQ-019 INT4: each active lane is a signed 4-bit value; LANES products a*b are summed.
REQ-020 INT8: active lanes pair (2k, 2k+1) relative to HDR_LANES; lane 2k+1 is the high nibble of a signed 8-bit value; LANES/2 products are summed.
REQ-021 Beat accepted on a rising edge with in_valid && in_ready; mode, in_first, in_last travel with the beat.
REQ-022 Pipeline: S1 registers products; S2 registers the adder-tree sum, sign-extended to ACC_W; S3 updates the accumulator.
REQ-023 Without stall, a last beat accepted at edge T shall give out_valid=1 with its result after edge T+3.
REQ-024 Full throughput: one beat per cycle while out_ready=1.
REQ-025 in_ready = !(out_valid && !out_ready); while stalled all stages hold, acc_out/ovf stay stable, no beat is lost or duplicated.
REQ-026 out_valid clears on the edge where out_valid && out_ready, unless a new last beat completes on that edge.
REQ-027 S3 accumulate: if the beat is first, or the first beat after a last beat, acc = sum; otherwise acc = acc + sum, computed at ACC_W+1 bits.
REQ-028 SAT=1: out-of-range results clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; SAT=0: keep the low ACC_W bits.
REQ-029 Any out-of-range step sets ovf in either SAT mode; ovf is sticky within the group and clears when the group's first beat reaches S3.
REQ-030 in_first && in_last on one beat is a single-beat group.
REQ-031 Mode may differ between beats of one group; each beat uses its own mode.
REQ-032 clr: on that edge, all stage valids, accumulator, out_valid and ovf go to 0; beats in flight are discarded; clr overrides a simultaneous accept.

Reset
REQ-033 While rst_n=0: out_valid=0, acc_out=0, ovf=0, in_ready=1, all stage valids and the accumulator are 0, asserted immediately without waiting for clk.
REQ-034 Reset mid-group discards the group; the first beat after reset release is treated as first.

Verification
REQ-035 INT4, active lanes a=1 and b=1, header lanes 0xF; single beat first+last at edge T -> out_valid after T+3, acc_out=64, ovf=0.
REQ-036 INT4, all a=-8 and b=-8; 3-beat group back-to-back -> acc_out=12288, one out_valid pulse.
REQ-037 INT8, all a=-128 and b=-128 (524288 per beat); 16-beat group, SAT=1 -> acc_out=8388607, ovf=1; next single-beat group with a=b=1 -> acc_out=32, ovf=0.
REQ-038 Two single-beat INT4 groups (64, then 128) with out_ready low for 5 cycles after the first result -> acc_out holds 64 and in_ready=0 throughout the stall; then 64 and 128 are emitted in order.
REQ-039 clr asserted one cycle after a last beat is accepted -> no out_valid for that group; next group result is correct.
REQ-040 rst_n pulsed low mid-edge during a 4-beat group -> outputs zero immediately; a new 1-beat group of 64 returns 64.
